// File: rtl/uparc_dbus_wbuf.sv
// Posted write buffer between the LSU D-bus master and the system data bus.
// Optional early-read bypass of queued writes: define UPARC_WBUF_RDBYPASS_EN.
`ifndef UPARC_ADDR_WIDTH
`define UPARC_ADDR_WIDTH 32
`endif
`ifndef UPARC_BEN_WIDTH
`define UPARC_BEN_WIDTH 4
`endif
`ifndef UPARC_DATA_WIDTH
`define UPARC_DATA_WIDTH 32
`endif

module uparc_dbus_wbuf #(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [`UPARC_ADDR_WIDTH-1:0]  i_DAddr,
  input  logic                          i_DCmd,
  input  logic                          i_DRnW,
  input  logic [`UPARC_BEN_WIDTH-1:0]   i_DBen,
  input  logic [`UPARC_DATA_WIDTH-1:0]  i_DData,
  output logic [`UPARC_DATA_WIDTH-1:0]  o_DData,
  output logic                          o_DRdy,
  output logic                          o_DErr,
  output logic [`UPARC_ADDR_WIDTH-1:0]  o_SAddr,
  output logic                          o_SCmd,
  output logic                          o_SRnW,
  output logic [`UPARC_BEN_WIDTH-1:0]   o_SBen,
  output logic [`UPARC_DATA_WIDTH-1:0]  o_SData,
  input  logic [`UPARC_DATA_WIDTH-1:0]  i_SData,
  input  logic                          i_SRdy,
  input  logic                          i_SErr,
  output logic                          o_idle,
  output logic                          o_werr,
  input  logic                          i_werr_clr,
  output logic [1:0]                    dbg_state
);

  localparam int AW = `UPARC_ADDR_WIDTH;
  localparam int BW = `UPARC_BEN_WIDTH;
  localparam int DW = `UPARC_DATA_WIDTH;
  localparam int EW = AW + BW + DW;
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  // Handshake: a request (i_DCmd / o_SCmd) stays asserted with stable
  // attributes until the responder raises Rdy or Err in the same cycle;
  // that cycle completes the transfer and read data is valid only then.

  state_t          state, state_nxt;
  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;

  logic            rd_req, wr_req, full, push, pop, byp_ok;
  logic [EW-1:0]   head, next_entry, in_entry;

  logic [AW-1:0]   s_addr_nxt;
  logic            s_cmd_nxt, s_rnw_nxt;
  logic [BW-1:0]   s_ben_nxt;
  logic [DW-1:0]   s_data_nxt;

  assign rd_req   = i_DCmd & i_DRnW;
  assign wr_req   = i_DCmd & ~i_DRnW;
  assign full     = (count == FULL_CNT);
  assign push     = wr_req & ~full;
  assign in_entry = {i_DAddr, i_DBen, i_DData};
  assign head     = mem[rd_ptr];
  // With one entry left and a push landing now, the follower is the input itself.
  assign next_entry = ((count == (PW+1)'(1)) && push) ? in_entry : mem[rd_ptr + PW'(1)];

`ifdef UPARC_WBUF_RDBYPASS_EN
  logic rd_hazard;

  // The in-flight head is excluded while in WR: it completes before any read issues.
  always_comb begin
    rd_hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((k != 0 || state != ST_WR) && ((PW+1)'(k) < count) &&
          (mem[rd_ptr + PW'(k)][EW-1 -: AW-2] == i_DAddr[AW-1:2]))
        rd_hazard = 1'b1;
    end
  end

  assign byp_ok = rd_req & ~rd_hazard;
`else
  assign byp_ok = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    s_addr_nxt = o_SAddr;
    s_cmd_nxt  = o_SCmd;
    s_rnw_nxt  = o_SRnW;
    s_ben_nxt  = o_SBen;
    s_data_nxt = o_SData;
    case (state)
      ST_IDLE: begin
        if (count != '0 && !byp_ok) begin
          {s_addr_nxt, s_ben_nxt, s_data_nxt} = head;
          s_cmd_nxt = 1'b1;
          s_rnw_nxt = 1'b0;
          state_nxt = ST_WR;
        end else if (rd_req) begin
          s_addr_nxt = i_DAddr;
          s_ben_nxt  = i_DBen;
          s_data_nxt = '0;
          s_cmd_nxt  = 1'b1;
          s_rnw_nxt  = 1'b1;
          state_nxt  = ST_RD;
        end
      end
      ST_WR: begin
        if (i_SRdy || i_SErr) begin
          pop = 1'b1;
          if ((count > (PW+1)'(1) || push) && !byp_ok) begin
            {s_addr_nxt, s_ben_nxt, s_data_nxt} = next_entry;
            s_cmd_nxt = 1'b1;
            s_rnw_nxt = 1'b0;
          end else begin
            s_addr_nxt = '0;
            s_ben_nxt  = '0;
            s_data_nxt = '0;
            s_cmd_nxt  = 1'b0;
            s_rnw_nxt  = 1'b0;
            state_nxt  = ST_IDLE;
          end
        end
      end
      ST_RD: begin
        if (i_SRdy || i_SErr) begin
          s_addr_nxt = '0;
          s_ben_nxt  = '0;
          s_data_nxt = '0;
          s_cmd_nxt  = 1'b0;
          s_rnw_nxt  = 1'b0;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= ST_IDLE;
      o_SAddr <= '0;
      o_SCmd  <= 1'b0;
      o_SRnW  <= 1'b0;
      o_SBen  <= '0;
      o_SData <= '0;
    end else begin
      state   <= state_nxt;
      o_SAddr <= s_addr_nxt;
      o_SCmd  <= s_cmd_nxt;
      o_SRnW  <= s_rnw_nxt;
      o_SBen  <= s_ben_nxt;
      o_SData <= s_data_nxt;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read within the occupied window.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                     o_werr <= 1'b0;
    else if (state == ST_WR && i_SErr) o_werr <= 1'b1;
    else if (i_werr_clr)           o_werr <= 1'b0;
  end

  logic rd_done;
  assign rd_done   = (state == ST_RD) && rd_req && i_SRdy && !i_SErr;
  assign o_DRdy    = wr_req ? ~full : rd_done;
  assign o_DErr    = (state == ST_RD) && rd_req && i_SErr;
  assign o_DData   = rd_done ? i_SData : '0;
  assign o_idle    = (count == '0) && (state == ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uparc_dbus_wbuf.sv
// Directed testbench for uparc_dbus_wbuf; bypass scenario runs only with UPARC_WBUF_RDBYPASS_EN.
`ifndef UPARC_ADDR_WIDTH
`define UPARC_ADDR_WIDTH 32
`endif
`ifndef UPARC_BEN_WIDTH
`define UPARC_BEN_WIDTH 4
`endif
`ifndef UPARC_DATA_WIDTH
`define UPARC_DATA_WIDTH 32
`endif

module tb_uparc_dbus_wbuf;

  logic        clk, nrst;
  logic [31:0] i_DAddr, i_DData, o_DData, o_SAddr, o_SData, i_SData;
  logic        i_DCmd, i_DRnW, o_DRdy, o_DErr, o_SCmd, o_SRnW;
  logic [3:0]  i_DBen, o_SBen;
  logic        i_SRdy, i_SErr, o_idle, o_werr, i_werr_clr;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  uparc_dbus_wbuf #(.DEPTH(4)) dut (
    .clk(clk), .nrst(nrst),
    .i_DAddr(i_DAddr), .i_DCmd(i_DCmd), .i_DRnW(i_DRnW), .i_DBen(i_DBen),
    .i_DData(i_DData), .o_DData(o_DData), .o_DRdy(o_DRdy), .o_DErr(o_DErr),
    .o_SAddr(o_SAddr), .o_SCmd(o_SCmd), .o_SRnW(o_SRnW), .o_SBen(o_SBen),
    .o_SData(o_SData), .i_SData(i_SData), .i_SRdy(i_SRdy), .i_SErr(i_SErr),
    .o_idle(o_idle), .o_werr(o_werr), .i_werr_clr(i_werr_clr),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_DCmd = 1'b0; i_DRnW = 1'b0; i_DAddr = '0; i_DBen = '0; i_DData = '0;
    i_SData = '0; i_SRdy = 1'b0; i_SErr = 1'b0; i_werr_clr = 1'b0;
  endtask

  task automatic drive_wr(input logic [31:0] a, input logic [31:0] d);
    i_DCmd = 1'b1; i_DRnW = 1'b0; i_DAddr = a; i_DBen = 4'hF; i_DData = d;
  endtask

  task automatic drive_rd(input logic [31:0] a);
    i_DCmd = 1'b1; i_DRnW = 1'b1; i_DAddr = a; i_DBen = 4'hF; i_DData = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    edge_step();
  endtask

  task automatic test_reset();
    idle_inputs();
    nrst = 1'b0;
    #12;
    total++; if (o_SCmd !== 1'b0) begin bad++; $display("FAIL reset_scmd got %b exp 0", o_SCmd); end
    total++; if (o_SAddr !== 32'h0) begin bad++; $display("FAIL reset_saddr got %h exp 0", o_SAddr); end
    total++; if (o_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got %b exp 1", o_idle); end
    total++; if (o_werr !== 1'b0) begin bad++; $display("FAIL reset_werr got %b exp 0", o_werr); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    @(posedge clk); #1 nrst = 1'b1;
    edge_step();
  endtask

  task automatic test_fill_stall();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      drive_wr(32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i));
      #1;
      total++; if (o_DRdy !== 1'b1) begin bad++; $display("FAIL fill_rdy%0d got %b exp 1", i, o_DRdy); end
      edge_step();
    end
    drive_wr(32'h110, 32'hA000_0004);
    #1;
    total++; if (o_DRdy !== 1'b0) begin bad++; $display("FAIL full_stall got %b exp 0", o_DRdy); end
    total++; if (o_SCmd !== 1'b1 || o_SAddr !== 32'h100 || o_SRnW !== 1'b0) begin bad++; $display("FAIL head_issue got cmd=%b addr=%h exp cmd=1 addr=100", o_SCmd, o_SAddr); end
    total++; if (o_SData !== 32'hA000_0000) begin bad++; $display("FAIL head_data got %h exp a0000000", o_SData); end
    edge_step();
    i_SRdy = 1'b1;
    #1;
    total++; if (o_DRdy !== 1'b0) begin bad++; $display("FAIL no_full_bypass got %b exp 0", o_DRdy); end
    edge_step();
    i_SRdy = 1'b0;
    #1;
    total++; if (o_DRdy !== 1'b1) begin bad++; $display("FAIL slot_freed got %b exp 1", o_DRdy); end
    total++; if (o_SAddr !== 32'h104) begin bad++; $display("FAIL second_head got %h exp 104", o_SAddr); end
    edge_step();
    idle_inputs();
    i_SRdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      total++; if (o_SCmd !== 1'b1 || o_SAddr !== 32'h104 + 32'(4*j)) begin bad++; $display("FAIL drain%0d got cmd=%b addr=%h exp addr=%h", j, o_SCmd, o_SAddr, 32'h104 + 32'(4*j)); end
      edge_step();
    end
    #1;
    total++; if (o_idle !== 1'b1 || o_SCmd !== 1'b0) begin bad++; $display("FAIL fill_done got idle=%b cmd=%b exp 1 0", o_idle, o_SCmd); end
    i_SRdy = 1'b0;
    edge_step();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    i_SRdy = 1'b1;
    drive_wr(32'h100, 32'h1); edge_step();
    drive_wr(32'h104, 32'h2); edge_step();
    drive_wr(32'h108, 32'h3);
    #1;
    total++; if (o_SCmd !== 1'b1 || o_SAddr !== 32'h100) begin bad++; $display("FAIL b2b_0 got cmd=%b addr=%h exp 1 100", o_SCmd, o_SAddr); end
    edge_step();
    i_DCmd = 1'b0;
    #1;
    total++; if (o_SCmd !== 1'b1 || o_SAddr !== 32'h104) begin bad++; $display("FAIL b2b_1 got cmd=%b addr=%h exp 1 104", o_SCmd, o_SAddr); end
    edge_step();
    total++; if (o_SCmd !== 1'b1 || o_SAddr !== 32'h108 || o_SData !== 32'h3) begin bad++; $display("FAIL b2b_2 got cmd=%b addr=%h data=%h exp 1 108 3", o_SCmd, o_SAddr, o_SData); end
    edge_step();
    total++; if (o_SCmd !== 1'b0 || o_idle !== 1'b1) begin bad++; $display("FAIL b2b_idle got cmd=%b idle=%b exp 0 1", o_SCmd, o_idle); end
    idle_inputs();
    edge_step();
  endtask

  task automatic test_read_after_write();
    idle_inputs();
    drive_wr(32'h200, 32'hDEADBEEF); edge_step();
    drive_rd(32'h200);
    #1;
    total++; if (o_DRdy !== 1'b0) begin bad++; $display("FAIL raw_stall got %b exp 0", o_DRdy); end
    edge_step();
    total++; if (o_SRnW !== 1'b0 || o_SAddr !== 32'h200 || o_SData !== 32'hDEADBEEF) begin bad++; $display("FAIL raw_wr_first got rnw=%b addr=%h data=%h", o_SRnW, o_SAddr, o_SData); end
    i_SRdy = 1'b1;
    #1;
    total++; if (o_DRdy !== 1'b0 || o_DData !== 32'h0) begin bad++; $display("FAIL raw_wr_done got rdy=%b data=%h exp 0 0", o_DRdy, o_DData); end
    edge_step();
    i_SRdy = 1'b0;
    #1;
    total++; if (o_SCmd !== 1'b0) begin bad++; $display("FAIL raw_issue_gap got %b exp 0", o_SCmd); end
    edge_step();
    total++; if (o_SCmd !== 1'b1 || o_SRnW !== 1'b1 || o_SAddr !== 32'h200 || o_SData !== 32'h0 || o_SBen !== 4'hF) begin bad++; $display("FAIL raw_rd_issue got cmd=%b rnw=%b addr=%h data=%h ben=%h", o_SCmd, o_SRnW, o_SAddr, o_SData, o_SBen); end
    i_SData = 32'hDEADBEEF; i_SRdy = 1'b1;
    #1;
    total++; if (o_DRdy !== 1'b1 || o_DData !== 32'hDEADBEEF || o_DErr !== 1'b0) begin bad++; $display("FAIL raw_rd_data got rdy=%b data=%h err=%b exp 1 deadbeef 0", o_DRdy, o_DData, o_DErr); end
    edge_step();
    idle_inputs();
    #1;
    total++; if (o_SCmd !== 1'b0 || o_idle !== 1'b1 || o_DData !== 32'h0) begin bad++; $display("FAIL raw_end got cmd=%b idle=%b data=%h", o_SCmd, o_idle, o_DData); end
    edge_step();
  endtask

  task automatic test_werr();
    idle_inputs();
    drive_wr(32'h300, 32'h33); edge_step();
    idle_inputs(); edge_step();
    i_SErr = 1'b1;
    #1;
    total++; if (o_werr !== 1'b0) begin bad++; $display("FAIL werr_pre got %b exp 0", o_werr); end
    edge_step();
    i_SErr = 1'b0;
    edge_step();
    total++; if (o_werr !== 1'b1 || o_idle !== 1'b1) begin bad++; $display("FAIL werr_set got werr=%b idle=%b exp 1 1", o_werr, o_idle); end
    i_werr_clr = 1'b1; edge_step();
    i_werr_clr = 1'b0;
    total++; if (o_werr !== 1'b0) begin bad++; $display("FAIL werr_clr got %b exp 0", o_werr); end
    drive_wr(32'h304, 32'h34); edge_step();
    idle_inputs(); edge_step();
    i_SErr = 1'b1; i_werr_clr = 1'b1; edge_step();
    idle_inputs();
    total++; if (o_werr !== 1'b1) begin bad++; $display("FAIL werr_set_wins got %b exp 1", o_werr); end
    edge_step();
  endtask

  task automatic test_read_err();
    idle_inputs();
    drive_rd(32'h400);
    #1;
    total++; if (o_DRdy !== 1'b0) begin bad++; $display("FAIL rderr_wait got %b exp 0", o_DRdy); end
    edge_step();
    total++; if (o_SRnW !== 1'b1 || o_SAddr !== 32'h400 || dbg_state !== 2'd2) begin bad++; $display("FAIL rderr_issue got rnw=%b addr=%h st=%0d", o_SRnW, o_SAddr, dbg_state); end
    i_SErr = 1'b1; i_SData = 32'h5555_5555;
    #1;
    total++; if (o_DErr !== 1'b1 || o_DRdy !== 1'b0 || o_DData !== 32'h0) begin bad++; $display("FAIL rderr_resp got err=%b rdy=%b data=%h exp 1 0 0", o_DErr, o_DRdy, o_DData); end
    edge_step();
    idle_inputs();
    #1;
    total++; if (dbg_state !== 2'd0 || o_SCmd !== 1'b0 || o_werr !== 1'b1 || o_DErr !== 1'b0) begin bad++; $display("FAIL rderr_after got st=%0d cmd=%b werr=%b derr=%b", dbg_state, o_SCmd, o_werr, o_DErr); end
    i_werr_clr = 1'b1; edge_step();
    i_werr_clr = 1'b0; edge_step();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    drive_wr(32'h800, 32'h8); edge_step();
    drive_wr(32'h804, 32'h9); edge_step();
    idle_inputs();
    nrst = 1'b0;
    #1;
    total++; if (o_SCmd !== 1'b0 || o_idle !== 1'b1 || o_SAddr !== 32'h0) begin bad++; $display("FAIL rst_fifo got cmd=%b idle=%b addr=%h", o_SCmd, o_idle, o_SAddr); end
    edge_step();
    nrst = 1'b1;
    edge_step(); edge_step();
    total++; if (o_SCmd !== 1'b0 || o_idle !== 1'b1) begin bad++; $display("FAIL rst_discard got cmd=%b idle=%b exp 0 1", o_SCmd, o_idle); end
    drive_rd(32'h700); edge_step();
    total++; if (o_SCmd !== 1'b1 || o_SRnW !== 1'b1) begin bad++; $display("FAIL rst_rd_issue got cmd=%b rnw=%b exp 1 1", o_SCmd, o_SRnW); end
    nrst = 1'b0;
    #1;
    total++; if (o_SCmd !== 1'b0 || o_SRnW !== 1'b0 || o_SAddr !== 32'h0 || o_SBen !== 4'h0 || o_SData !== 32'h0 || dbg_state !== 2'd0 || o_idle !== 1'b1) begin bad++; $display("FAIL rst_mid_read got cmd=%b rnw=%b addr=%h st=%0d idle=%b", o_SCmd, o_SRnW, o_SAddr, dbg_state, o_idle); end
    idle_inputs();
    do_reset();
  endtask

`ifdef UPARC_WBUF_RDBYPASS_EN
  task automatic test_rd_bypass();
    idle_inputs();
    drive_wr(32'h500, 32'h50); edge_step();
    drive_wr(32'h504, 32'h54); edge_step();
    drive_rd(32'h600);
    #1;
    total++; if (o_SAddr !== 32'h500 || o_DRdy !== 1'b0) begin bad++; $display("FAIL byp_head got addr=%h rdy=%b", o_SAddr, o_DRdy); end
    i_SRdy = 1'b1; edge_step();
    i_SRdy = 1'b0; edge_step();
    total++; if (o_SCmd !== 1'b1 || o_SRnW !== 1'b1 || o_SAddr !== 32'h600) begin bad++; $display("FAIL byp_issue got cmd=%b rnw=%b addr=%h exp 1 1 600", o_SCmd, o_SRnW, o_SAddr); end
    i_SData = 32'h1234_5678; i_SRdy = 1'b1;
    #1;
    total++; if (o_DRdy !== 1'b1 || o_DData !== 32'h1234_5678) begin bad++; $display("FAIL byp_data got rdy=%b data=%h", o_DRdy, o_DData); end
    edge_step();
    idle_inputs(); edge_step();
    total++; if (o_SCmd !== 1'b1 || o_SRnW !== 1'b0 || o_SAddr !== 32'h504) begin bad++; $display("FAIL byp_resume got cmd=%b rnw=%b addr=%h exp 1 0 504", o_SCmd, o_SRnW, o_SAddr); end
    i_SRdy = 1'b1; edge_step();
    idle_inputs(); edge_step();
    drive_wr(32'h500, 32'h50); edge_step();
    drive_wr(32'h504, 32'h54); edge_step();
    drive_rd(32'h504);
    i_SRdy = 1'b1; edge_step();
    i_SRdy = 1'b0;
    #1;
    total++; if (o_SRnW !== 1'b0 || o_SAddr !== 32'h504) begin bad++; $display("FAIL byp_hazard got rnw=%b addr=%h exp 0 504", o_SRnW, o_SAddr); end
    i_SRdy = 1'b1; edge_step();
    i_SRdy = 1'b0; edge_step();
    total++; if (o_SRnW !== 1'b1 || o_SAddr !== 32'h504 || o_SCmd !== 1'b1) begin bad++; $display("FAIL byp_hazard_rd got rnw=%b addr=%h cmd=%b", o_SRnW, o_SAddr, o_SCmd); end
    i_SRdy = 1'b1; edge_step();
    idle_inputs(); edge_step();
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_fill_stall();
    test_back_to_back();
    test_read_after_write();
    test_werr();
    test_read_err();
`ifdef UPARC_WBUF_RDBYPASS_EN
    test_rd_bypass();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
